// File: rtl/thermal_head_pkg.sv
// Shared types and sizing helpers for the strobed thermal printhead model.
package thermal_head_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURN   = 2'd1,
    CUTOFF = 2'd2
  } strobe_state_e;

  function automatic int dots_per_strobe(input int head_width, input int num_strobes);
    return head_width / num_strobes;
  endfunction

  // Two spare bits let the load counter show overlong loads before it saturates.
  function automatic int bit_count_width(input int head_width);
    return $clog2(head_width) + 2;
  endfunction

  function automatic int burn_count_width(input int max_burn);
    return (max_burn < 2) ? 1 : $clog2(max_burn + 1);
  endfunction

endpackage

// File: rtl/strobe_ch.sv
// One strobe group: IDLE/BURN/CUTOFF state machine with burn-time supervision.
module strobe_ch
  import thermal_head_pkg::*;
#(
  parameter int MAX_BURN_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_dst,
  input  logic overheat_clear,
  output logic burn,
  output logic overheat
);

  localparam int            CW         = burn_count_width(MAX_BURN_CYCLES);
  localparam bit            CUTOFF_EN  = (MAX_BURN_CYCLES != 0);
  localparam logic [CW-1:0] CUT_AT     = CW'(MAX_BURN_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  strobe_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_burn_cnt, w_burn_cnt_nxt;
  logic          r_overheat;
  logic          w_set_overheat;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_burn_cnt_nxt = r_burn_cnt;
    w_set_overheat = 1'b0;
    case (r_state)
      IDLE: begin
        w_burn_cnt_nxt = '0;
        if (sync_dst) begin
          w_state_nxt    = BURN;
          w_burn_cnt_nxt = CW'(1);
        end
      end
      BURN: begin
        if (!sync_dst) begin
          w_state_nxt    = IDLE;
          w_burn_cnt_nxt = '0;
        end else if (CUTOFF_EN && (r_burn_cnt == CUT_AT)) begin
          w_state_nxt    = CUTOFF;
          w_set_overheat = 1'b1;
        end else if (r_burn_cnt != CNT_MAX) begin
          w_burn_cnt_nxt = r_burn_cnt + CW'(1);
        end
      end
      CUTOFF: begin
        // Re-arming requires DST to drop first.
        if (!sync_dst) begin
          w_state_nxt    = IDLE;
          w_burn_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_burn_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_burn_cnt <= '0;
      r_overheat <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_burn_cnt <= w_burn_cnt_nxt;
      if (w_set_overheat)      r_overheat <= 1'b1;
      else if (overheat_clear) r_overheat <= 1'b0;
    end
  end

  assign burn     = (r_state == BURN);
  assign overheat = r_overheat;

endmodule

// File: rtl/thermal_head_sync.sv
// Multi-flop synchroniser cell used for every asynchronous mech input.
module thermal_head_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_chain <= '0;
    else        r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/thermal_head_strobed.sv
// Thermal printhead model: synchronised serial load, latch, and per-group strobed burn.
module thermal_head_strobed
  import thermal_head_pkg::*;
#(
  parameter  int HEAD_WIDTH      = 384,
  parameter  int NUM_STROBES     = 6,
  parameter  int SYNC_STAGES     = 2,
  parameter  int MAX_BURN_CYCLES = 100000,
  localparam int BIT_COUNT_W     = bit_count_width(HEAD_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mech_clk,
  input  logic                   mech_data,
  input  logic                   mech_latch,
  input  logic [NUM_STROBES-1:0] mech_dst,
  input  logic                   overheat_clear,
  output logic                   head_active,
  output logic [HEAD_WIDTH-1:0]  head_active_dots,
  output logic [BIT_COUNT_W-1:0] load_bits,
  output logic                   load_error,
  output logic [NUM_STROBES-1:0] overheat
);

  localparam int                     DPS        = dots_per_strobe(HEAD_WIDTH, NUM_STROBES);
  localparam int                     NUM_IN     = NUM_STROBES + 3;
  localparam logic [BIT_COUNT_W-1:0] FULL_COUNT = BIT_COUNT_W'(HEAD_WIDTH);
  localparam logic [BIT_COUNT_W-1:0] COUNT_MAX  = '1;

  if ((HEAD_WIDTH < 2) || (SYNC_STAGES < 2) || ((HEAD_WIDTH % NUM_STROBES) != 0)) begin : g_bad_cfg
    $error("thermal_head_strobed: illegal HEAD_WIDTH/NUM_STROBES/SYNC_STAGES combination");
  end

  logic [NUM_IN-1:0]      w_async_in;
  logic [NUM_IN-1:0]      w_sync_in;
  logic                   w_sync_clk, w_sync_data, w_sync_latch;
  logic [NUM_STROBES-1:0] w_sync_dst;
  logic                   w_shift, w_latch;
  logic [NUM_STROBES-1:0] w_burn;

  logic                   r_clk_prev, r_latch_prev;
  logic [HEAD_WIDTH-1:0]  r_data_buffer, r_latch_buffer;
  logic [BIT_COUNT_W-1:0] r_bit_count, r_load_bits;
  logic                   r_load_error;

  assign w_async_in = {mech_dst, mech_latch, mech_data, mech_clk};

  for (genvar k = 0; k < NUM_IN; k++) begin : g_sync
    thermal_head_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_async_in[k]),
      .o_q   (w_sync_in[k])
    );
  end

  assign w_sync_clk   = w_sync_in[0];
  assign w_sync_data  = w_sync_in[1];
  assign w_sync_latch = w_sync_in[2];
  assign w_sync_dst   = w_sync_in[NUM_IN-1:3];

  assign w_shift = w_sync_clk & ~r_clk_prev;
  assign w_latch = ~w_sync_latch & r_latch_prev;

  // NOTE: the dot buffers are cleared on reset so a mid-line reset discards partial loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_prev     <= 1'b0;
      r_latch_prev   <= 1'b0;
      r_data_buffer  <= '0;
      r_latch_buffer <= '0;
      r_bit_count    <= '0;
      r_load_bits    <= '0;
      r_load_error   <= 1'b0;
    end else begin
      r_clk_prev   <= w_sync_clk;
      r_latch_prev <= w_sync_latch;
      r_load_error <= 1'b0;
      if (w_shift) r_data_buffer <= {r_data_buffer[HEAD_WIDTH-2:0], w_sync_data};
      if (w_latch) begin
        // Latch sees the pre-shift buffer; a coincident shift becomes bit 1 of the next load.
        r_latch_buffer <= r_data_buffer;
        r_load_bits    <= r_bit_count;
        r_load_error   <= (r_bit_count != FULL_COUNT);
        r_bit_count    <= w_shift ? BIT_COUNT_W'(1) : '0;
      end else if (w_shift && (r_bit_count != COUNT_MAX)) begin
        r_bit_count <= r_bit_count + BIT_COUNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_STROBES; g++) begin : g_strobe
    strobe_ch #(.MAX_BURN_CYCLES(MAX_BURN_CYCLES)) u_strobe_ch (
      .clk            (clk),
      .reset          (reset),
      .sync_dst       (w_sync_dst[g]),
      .overheat_clear (overheat_clear),
      .burn           (w_burn[g]),
      .overheat       (overheat[g])
    );
    assign head_active_dots[g*DPS +: DPS] = r_latch_buffer[g*DPS +: DPS] & {DPS{w_burn[g]}};
  end

  assign head_active = |w_burn;
  assign load_bits   = r_load_bits;
  assign load_error  = r_load_error;

endmodule

// File: doc/thermal_head_strobed.md
Name: thermal_head_strobed

Overview:
- Parametrised successor to the single-strobe head model: clk-domain model of a thermal printhead with a serial shift register, latch, and NUM_STROBES independent strobe (DST) groups.
- Mech inputs are asynchronous. They are synchronised and edge-detected, so no async FIFO is used.
- Adds per-load bit counting with a load-error flag, and per-strobe burn-time supervision with overheat cutoff.
- Sits between the mech input pins and the dot capture/line-assembly logic.

Parameters:
- HEAD_WIDTH, 384: number of dots. Must be ≥ 2.
- NUM_STROBES, 6: number of strobe groups. HEAD_WIDTH % NUM_STROBES must be 0 (elaboration assertion).
- SYNC_STAGES, 2: synchroniser depth for every mech input. Must be ≥ 2.
- MAX_BURN_CYCLES, 100000: clk cycles a strobe may burn before cutoff. 0 disables cutoff.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- mech_clk  in  1  async serial shift clock; data shifts on its rising edge
- mech_data  in  1  async serial data
- mech_latch  in  1  async latch; captures on its falling edge
- mech_dst  in  NUM_STROBES  async strobe enables, one per group
- overheat_clear  in  1  clears all overheat flags
- head_active  out  1  OR of all groups currently in BURN
- head_active_dots  out  HEAD_WIDTH  dots currently burning
- load_bits  out  BIT_COUNT_W  bit count captured at the last latch
- load_error  out  1  one-cycle pulse on a latch where the count ≠ HEAD_WIDTH
- overheat  out  NUM_STROBES  sticky per-group cutoff flags

Behaviour:
- Reset (asynchronous, active-low; clock clk): all registers clear, so every output is 0. Synchroniser chains and edge-detect history registers also clear to 0.
- Synchronisation:
  - Each input passes through a SYNC_STAGES flop chain.
  - An edge is detected by comparing the chain output with a one-cycle-delayed copy.
  - Every input event takes effect SYNC_STAGES+1 clk edges after the input changes.
- Shift: on a detected sync mech_clk rise, data_buffer <= {data_buffer[HEAD_WIDTH-2:0], sync_data}. sync_data is sampled in that same cycle. The first bit in ends up at the MSB after HEAD_WIDTH shifts.
- Bit counter:
  - BIT_COUNT_W = $clog2(HEAD_WIDTH)+2.
  - Increments on each shift and saturates at all-ones; it never wraps.
- Latch, on a detected sync mech_latch fall:
  - latch_buffer <= data_buffer (value before any shift in the same cycle).
  - load_bits <= current count.
  - load_error pulses for 1 cycle if the count ≠ HEAD_WIDTH.
  - Counter restarts at 0, or at 1 if a shift coincides with the latch.
- Latch while strobing: latch_buffer updates immediately and the new pattern appears on head_active_dots the next cycle. This is allowed; there is no error.
- Per-group FSM (strobe_ch), states IDLE / BURN / CUTOFF:
  - IDLE: sync_dst=1 → BURN, burn_cnt <= 1.
  - BURN:
    - sync_dst=0 → IDLE.
    - Otherwise burn_cnt++.
    - If MAX_BURN_CYCLES≠0 and burn_cnt == MAX_BURN_CYCLES → CUTOFF, and overheat[i] sets.
  - CUTOFF: dots forced off. sync_dst=0 → IDLE. A group cannot re-enter BURN until DST drops.
  - burn_cnt is ceil-log2 sized and cleared in IDLE.
- Outputs:
  - Group of dot j = j / (HEAD_WIDTH/NUM_STROBES).
  - head_active_dots[j] = latch_buffer[j] & (state[group]==BURN), taken from registered state with no extra pipeline stage.
  - head_active = |burn_mask.
- overheat_clear: clears the flags. If a set and a clear happen in the same cycle, the set wins.
- Reset mid-line: the buffer, counter and FSMs return to 0/IDLE immediately. Partial shifts are discarded.

Decomposition:
- Package thermal_head_pkg:
  - strobe_state_e (IDLE, BURN, CUTOFF).
  - Function dots_per_strobe(HEAD_WIDTH, NUM_STROBES).
  - Function bit_count_width(HEAD_WIDTH).
- Sub-module strobe_ch: one per group, generate-instantiated. Contains the FSM and burn counter. Inputs: sync_dst, overheat_clear. Outputs: burn, overheat.
- The existing synchroniser cell is reused for all inputs.

Test Plan:
All scenarios use HEAD_WIDTH=16, NUM_STROBES=4, SYNC_STAGES=2, MAX_BURN_CYCLES=8.
1. Shift 16'hA5C3 MSB-first, then drop the latch → latch_buffer = A5C3, load_bits = 16, no load_error. Raise dst=4'b1111 → head_active_dots = A5C3 exactly 3 clk edges after DST rises.
2. Shift 12 bits, then latch → load_bits = 12, load_error pulses for 1 cycle. Shift 40 bits, then latch → load_bits = 40, load_error pulses.
3. Pattern FFFF, dst = 4'b0100 → head_active_dots = 16'h0F00, head_active = 1. Lower dst → dots = 0 after 3 edges.
4. Hold dst[0] high for 20 cycles → group 0 burns 8 cycles, then CUTOFF (dots[3:0] = 0) and overheat = 4'b0001. Assert overheat_clear with dst still high → flag clears and the group stays off. Drop and re-raise dst → the group burns again.
5. Coincide a mech_clk rise with a mech_latch fall (same sync cycle) → the latch captures the pre-shift buffer and the counter restarts at 1.
6. Assert reset mid-shift with dst high → all outputs 0 immediately. After release, the first latch reports load_bits = the number of shifts made since release.
